// File: rtl/contador_pkg.sv
//------------------------------------------------------------------------------
// Module : contador_pkg
// Brief  : Mode encodings shared by the counter RTL and its reference model.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package contador_pkg;

    localparam logic [1:0] MODO_UP        = 2'b00;
    localparam logic [1:0] MODO_DOWN      = 2'b01;
    localparam logic [1:0] MODO_DOWN_STEP = 2'b10;
    localparam logic [1:0] MODO_LOAD      = 2'b11;

endpackage : contador_pkg

`default_nettype wire

// File: rtl/contador_param_if.sv
//------------------------------------------------------------------------------
// Module : contador_param_if
// Brief  : Control/data bundle of the parametrised counter.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface contador_param_if #(
    parameter int WIDTH = 4
) ();

    logic             enable;
    logic [1:0]       modo;
    logic [WIDTH-1:0] D;
    logic [WIDTH-1:0] Q;
    logic             rco;
    logic             valid;

    modport master (
        output enable, modo, D,
        input  Q, rco, valid
    );

    modport slave (
        input  enable, modo, D,
        output Q, rco, valid
    );

endinterface : contador_param_if

`default_nettype wire

// File: rtl/contador_next.sv
//------------------------------------------------------------------------------
// Module : contador_next
// Brief  : Next-state and carry/borrow logic of the counter (combinational).
//          Macro CONTADOR_SAT_EN selects saturating instead of wrapping.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module contador_next
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  wire logic [WIDTH-1:0] i_q,
    input  wire logic [1:0]       i_modo,
    input  wire logic [WIDTH-1:0] i_d,
    output      logic [WIDTH-1:0] o_q_next,
    output      logic             o_wrap
);

    localparam logic [WIDTH:0] c_ONE  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] c_STEP = (WIDTH+1)'(STEP);

    logic [WIDTH:0] w_q_ext;
    logic [WIDTH:0] w_res;

    // One extra bit holds the carry (up) or the borrow sign (down).
    always_comb begin
        w_q_ext  = {1'b0, i_q};
        w_res    = w_q_ext;
        o_wrap   = 1'b0;
        o_q_next = i_q;
        case (i_modo)
            MODO_UP:        w_res = w_q_ext + c_ONE;
            MODO_DOWN:      w_res = w_q_ext - c_ONE;
            MODO_DOWN_STEP: w_res = w_q_ext - c_STEP;
            MODO_LOAD:      w_res = {1'b0, i_d};
        endcase
        o_wrap = w_res[WIDTH];
`ifdef CONTADOR_SAT_EN
        if (o_wrap) begin
            o_q_next = (i_modo == MODO_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};
        end else begin
            o_q_next = w_res[WIDTH-1:0];
        end
`else
        o_q_next = w_res[WIDTH-1:0];
`endif
    end

endmodule : contador_next

`default_nettype wire

// File: rtl/contador_param.sv
//------------------------------------------------------------------------------
// Module : contador_param
// Brief  : Parametrised up/down/step/load counter with registered rco/valid.
//          Optional saturation via macro CONTADOR_SAT_EN.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module contador_param
    import contador_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  wire logic         clk,
    input  wire logic         reset_L,
    contador_param_if.slave   bus
);

    logic [WIDTH-1:0] r_q;
    logic             r_rco;
    logic             r_valid;

    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap;

    contador_next #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_next (
        .i_q      (r_q),
        .i_modo   (bus.modo),
        .i_d      (bus.D),
        .o_q_next (w_q_next),
        .o_wrap   (w_wrap)
    );

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_q     <= '0;
            r_rco   <= 1'b0;
            r_valid <= 1'b0;
        end else if (bus.enable) begin
            r_q     <= w_q_next;
            r_rco   <= w_wrap;
            r_valid <= 1'b1;
        end else begin
            // Hold: rco is a pulse, so it drops while idle.
            r_rco   <= 1'b0;
        end
    end

    assign bus.Q     = r_q;
    assign bus.rco   = r_rco;
    assign bus.valid = r_valid;

endmodule : contador_param

`default_nettype wire

// File: doc/contador_param.md
Name: contador_param

Overview:
- Parametrised successor to the 4-bit contadorB counter.
- Width is set by WIDTH; the down-by-N step is set by STEP.
- Four modes are selected by `modo`: up-count, down-count, down-by-STEP, and parallel load.
- Adds a registered terminal/wrap flag `rco`, a count-in-progress flag `valid`, and an optional saturating mode. It is the counter leaf for the tarea3 verification environment (driver/checker/scoreboard).

Parameters:
- WIDTH, 4, width of `D` and `Q`; legal range 2..32.
- STEP, 3, decrement amount in mode 2'b10; legal range 1..2^WIDTH-1.

Ports:
- clk, input, 1, rising-edge clock; the only clock.
- reset_L, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
- enable, input, 1, count/load qualifier; 0 = hold.
- modo, input, 2, operation select (encodings in Behaviour).
- D, input, WIDTH, parallel load value used in mode 2'b11.
- Q, output, WIDTH, registered count value.
- rco, output, 1, registered ripple-carry/borrow pulse.
- valid, output, 1, registered; 1 once Q holds a value produced by a count or load after reset.

Behaviour:
- Reset: reset_L=0 at a rising edge sets Q=0, rco=0, valid=0. Reset overrides enable and modo, including mid-count.
- All outputs are registered. Inputs are sampled at edge k; the result is visible after edge k (one-cycle latency).
- enable=0: Q holds, rco=0, valid holds.
- Modes with enable=1 (M = 2^WIDTH-1):
  - 2'b00: Q <= Q+1 mod 2^WIDTH. rco=1 iff Q==M before the edge (Q becomes 0).
  - 2'b01: Q <= Q-1 mod 2^WIDTH. rco=1 iff Q==0 before the edge (Q becomes M).
  - 2'b10: Q <= Q-STEP mod 2^WIDTH. rco=1 iff Q<STEP before the edge (borrow).
  - 2'b11: Q <= D. rco=0.
- valid <= 1 on any enabled operation. valid clears only on reset.
- rco is a single-cycle pulse, high only in the cycle where Q shows the wrapped value. Consecutive wraps (e.g. WIDTH=2 cycling) may produce rco on consecutive cycles.
- Arithmetic is computed at WIDTH+1 bits. The carry/borrow bit drives rco; the low WIDTH bits drive Q.
- modo changing mid-count takes effect at the next edge. There is no pipeline state beyond Q, rco and valid.
- No X propagation: modo is fully decoded. D is only sampled in mode 2'b11.

Optional Feature:
- Macro CONTADOR_SAT_EN.
- Defined:
  - Modes 00, 01 and 10 saturate instead of wrapping. Up-count clamps at M; down-count and down-by-STEP clamp at 0.
  - rco=1 in every enabled cycle where saturation would otherwise have wrapped, whether Q changed or was already at the limit.
- Undefined: modular wrap exactly as above. Port list is identical in both builds.

Decomposition:
- Package contador_pkg holds the mode localparams MODO_UP=2'b00, MODO_DOWN=2'b01, MODO_DOWN_STEP=2'b10, MODO_LOAD=2'b11. The scoreboard reuses these for its reference model.
- One combinational sub-module, contador_next:
  - Inputs: Q, modo, D.
  - Outputs: q_next and wrap.
  - Parametrised by WIDTH and STEP; contains the CONTADOR_SAT_EN logic.
- The top level holds only the registers, reset and enable gating.

Test Plan (WIDTH=4, STEP=3 unless noted):
1. Hold reset_L=0 for 2 edges with enable=1 and modo=00. Then release for 20 cycles. Required: Q=0, rco=0, valid=0 during reset. Then Q=1..15, 0, 1..4, with rco=1 only in the cycle Q=0 after 15.
2. Load D=4'hA (modo=11), then switch to modo=10 for 5 cycles. Required: Q=A, 7, 4, 1, E(rco=1), B; valid=1 from the load cycle onward.
3. From Q=0, modo=01 for 3 cycles. Required: Q=F(rco=1), E, D. Then enable=0 for 4 cycles: Q=D held, rco=0.
4. Assert reset_L=0 mid-count at Q=9 in modo=00. Required: next Q=0, valid=0. After release the count resumes 1, 2, ...
5. CONTADOR_SAT_EN build: load F, modo=00 for 2 cycles. Required: Q=F, F with rco=1 each cycle. Load 1, modo=10. Required: Q=0, rco=1.
6. WIDTH=8, STEP=5: load 8'h02, modo=10. Required: Q=8'hFD, rco=1. Random 2000-cycle run checked against the scoreboard model: zero mismatches.
